// File: rtl/nn_pkg.sv
// Shared constants and types for the training datapath.
// Labels are 4 bits wide; any code at or above CLASSES is treated as invalid.
package nn_pkg;
   localparam int         IMG_SIZE      = 256;
   localparam int         CLASSES       = 10;
   localparam int         LEARNING_RATE = 3;
   localparam logic [7:0] DELTA_POS     = 8'h20;
   localparam logic [7:0] DELTA_NEG     = 8'hE0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } upd_state_t;
endpackage

// File: rtl/weight_update_ctrl_if.sv
// Request/response bundle between the training sequencer and its requester/RAM.
interface weight_update_ctrl_if #(
   parameter int IMG_SIZE = nn_pkg::IMG_SIZE,
   parameter int CLASSES  = nn_pkg::CLASSES
);
   logic                    start;
   logic [IMG_SIZE-1:0]     img;
   logic [3:0]              target;
   logic [3:0]              predicted;
   logic [7:0]              bram_addr;
   logic                    en_update;
   logic [CLASSES-1:0][7:0] weight_deltas;
   logic                    busy;
   logic                    done;
   logic                    label_err;

   modport master (
      output start, img, target, predicted,
      input  bram_addr, en_update, weight_deltas, busy, done, label_err
   );

   modport slave (
      input  start, img, target, predicted,
      output bram_addr, en_update, weight_deltas, busy, done, label_err
   );
endinterface

// File: rtl/weight_update_ctrl_delta_gen.sv
// Combinational per-class delta lanes; isolated so other training rules can replace it.
module delta_gen #(
   parameter int         CLASSES   = nn_pkg::CLASSES,
   parameter logic [7:0] DELTA_POS = nn_pkg::DELTA_POS,
   parameter logic [7:0] DELTA_NEG = nn_pkg::DELTA_NEG
) (
   input  logic [3:0]              target_i,
   input  logic [3:0]              predicted_i,
   input  logic                    active_i,
   output logic [CLASSES-1:0][7:0] deltas_o
);
   for (genvar c = 0; c < CLASSES; c++) begin : g_lane
      assign deltas_o[c] = !active_i                 ? 8'h00     :
                           (target_i    == 4'(c))    ? DELTA_POS :
                           (predicted_i == 4'(c))    ? DELTA_NEG : 8'h00;
   end
endmodule

// File: rtl/weight_update_ctrl.sv
// Training-time sequencer: sweeps every pixel address, waits out the BRAM read
// latency, then issues one delta write per active pixel.
module weight_update_ctrl #(
   parameter int         IMG_SIZE  = nn_pkg::IMG_SIZE,
   parameter int         CLASSES   = nn_pkg::CLASSES,
   parameter int         RD_LAT    = 1,
   parameter logic [7:0] DELTA_POS = nn_pkg::DELTA_POS,
   parameter logic [7:0] DELTA_NEG = nn_pkg::DELTA_NEG
) (
   input  logic                 clk,
   input  logic                 rst_n,
   weight_update_ctrl_if.slave  upd
);
   import nn_pkg::*;

   localparam int                WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [7:0]        LAST_ADDR = 8'(IMG_SIZE - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_LAT - 1);

   upd_state_t          state_q, state_d;
   logic [7:0]          addr_q, addr_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [IMG_SIZE-1:0] img_q, img_d;
   logic [3:0]          target_q, target_d;
   logic [3:0]          predicted_q, predicted_d;
   logic                label_err_q, label_err_d;
   logic                lbl_bad;

   assign lbl_bad = (32'(upd.target)    >= 32'(CLASSES)) ||
                    (32'(upd.predicted) >= 32'(CLASSES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wait_q      <= '0;
         img_q       <= '0;
         target_q    <= '0;
         predicted_q <= '0;
         label_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wait_q      <= wait_d;
         img_q       <= img_d;
         target_q    <= target_d;
         predicted_q <= predicted_d;
         label_err_q <= label_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wait_d      = wait_q;
      img_d       = img_q;
      target_d    = target_q;
      predicted_d = predicted_q;
      label_err_d = label_err_q;
      unique case (state_q)
         IDLE: begin
            if (upd.start) begin
               img_d       = upd.img;
               target_d    = upd.target;
               predicted_d = upd.predicted;
               label_err_d = lbl_bad;
               addr_d      = '0;
               wait_d      = '0;
               // A correct classification has nothing to learn; skip straight to DONE.
               state_d     = (lbl_bad || upd.target == upd.predicted) ? DONE : READ;
            end
         end
         READ: begin
            if (wait_q == LAST_WAIT) begin
               wait_d  = '0;
               state_d = WRITE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         WRITE: begin
            if (addr_q == LAST_ADDR) begin
               state_d = DONE;
            end else begin
               addr_d  = addr_q + 8'd1;
               state_d = READ;
            end
         end
         DONE: begin
            addr_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from registered state so reset clears them at once.
   assign upd.bram_addr = addr_q;
   assign upd.en_update = (state_q == WRITE) && img_q[addr_q];
   assign upd.busy      = (state_q != IDLE);
   assign upd.done      = (state_q == DONE);
   assign upd.label_err = label_err_q;

   delta_gen #(
      .CLASSES   (CLASSES),
      .DELTA_POS (DELTA_POS),
      .DELTA_NEG (DELTA_NEG)
   ) u_delta_gen (
      .target_i    (target_q),
      .predicted_i (predicted_q),
      .active_i    (state_q == WRITE),
      .deltas_o    (upd.weight_deltas)
   );
endmodule

// File: tb/tb_weight_update_ctrl.sv
// Bench for weight_update_ctrl: vector table with a write scoreboard on the
// RD_LAT=1 instance, plus hand sequences for reset and the RD_LAT=2 instance.
module tb_weight_update_ctrl;
   import nn_pkg::*;

   typedef struct {
      logic [255:0] img;
      logic [3:0]   tgt;
      logic [3:0]   prd;
      int           poke;
      int           exp_done;
      int           exp_nz;
      logic         exp_lerr;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      int          t;
      logic [79:0] dl;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   weight_update_ctrl_if #(.IMG_SIZE(256), .CLASSES(10)) u1 ();
   weight_update_ctrl_if #(.IMG_SIZE(256), .CLASSES(10)) u2 ();

   weight_update_ctrl #(.RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .upd(u1));
   weight_update_ctrl #(.RD_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .upd(u2));

   int   pass_cnt = 0;
   int   total    = 0;
   int   ncyc     = 0;
   int   k_cyc    = 0;
   int   nz_cnt, busy_cnt, done_cnt, done_t, addr_seq_err;
   logic lerr1;
   wr_t  exp_q[$];
   vec_t vecs[7];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [79:0] lanes(input logic [3:0] t, input logic [3:0] p);
      logic [9:0][7:0] d;
      d = '0;
      if (t < 4'd10) d[t] = 8'h20;
      if (p < 4'd10) d[p] = 8'hE0;
      return d;
   endfunction

   // Monitor on the RD_LAT=1 instance; pops one expected write per en_update.
   initial begin : mon
      wr_t e;
      forever begin
         @(negedge clk);
         ncyc++;
         if (rst_n) begin
            if (u1.weight_deltas != '0) begin
               if (u1.bram_addr != 8'(nz_cnt)) addr_seq_err++;
               nz_cnt++;
            end
            if (ncyc - k_cyc == 1) lerr1 = u1.label_err;
            if (u1.busy) busy_cnt++;
            if (u1.done) begin
               done_cnt++;
               done_t = ncyc - k_cyc;
            end
            if (u1.en_update) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 96'(u1.en_update), 96'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 96'(u1.bram_addr), 96'(e.addr));
                  check("wr_cycle", 96'(ncyc - k_cyc), 96'(e.t));
                  check("wr_deltas", 96'(u1.weight_deltas), 96'(e.dl));
               end
            end
         end
      end
   end

   task automatic start_vec(input vec_t v);
      @(negedge clk);
      u1.img       = v.img;
      u1.target    = v.tgt;
      u1.predicted = v.prd;
      u1.start     = 1'b1;
      @(posedge clk);
      #1;
      u1.start     = 1'b0;
      k_cyc        = ncyc;
      nz_cnt       = 0;
      busy_cnt     = 0;
      done_cnt     = 0;
      done_t       = -1;
      addr_seq_err = 0;
      lerr1        = 1'bx;
      exp_q.delete();
      if (v.exp_nz != 0)
         for (int a = 0; a < 256; a++)
            if (v.img[a]) exp_q.push_back('{8'(a), (a + 1) * 2, lanes(v.tgt, v.prd)});
   endtask

   task automatic finish_vec(input string tag, input vec_t v);
      int rel = 0;
      while (done_cnt == 0 && rel < 1500) begin
         @(negedge clk);
         rel++;
         if (v.poke != 0 && rel == v.poke) begin
            u1.start     = 1'b1;
            u1.target    = 4'd1;
            u1.predicted = 4'd1;
         end else begin
            u1.start = 1'b0;
         end
      end
      repeat (4) @(negedge clk);
      check({tag, "_done_cycle"}, 96'(done_t), 96'(v.exp_done));
      check({tag, "_done_count"}, 96'(done_cnt), 96'd1);
      check({tag, "_busy_cycles"}, 96'(busy_cnt), 96'(v.exp_done));
      check({tag, "_delta_cycles"}, 96'(nz_cnt), 96'(v.exp_nz));
      check({tag, "_addr_sweep_err"}, 96'(addr_seq_err), 96'd0);
      check({tag, "_writes_missing"}, 96'(exp_q.size()), 96'd0);
      check({tag, "_label_err_k1"}, 96'(lerr1), 96'(v.exp_lerr));
      check({tag, "_label_err_sticky"}, 96'(u1.label_err), 96'(v.exp_lerr));
      check({tag, "_idle_addr"}, 96'(u1.bram_addr), 96'd0);
   endtask

   initial begin : main
      logic [255:0] sparse, patt;
      logic [79:0]  first_dl;
      int           rel, hold5, en2, d2t, first_t;

      u1.start = 1'b0; u1.img = '0; u1.target = '0; u1.predicted = '0;
      u2.start = 1'b0; u2.img = '0; u2.target = '0; u2.predicted = '0;
      sparse = '0;
      sparse[0]   = 1'b1;
      sparse[255] = 1'b1;
      patt = {8{32'hA5C3_0F96}};

      vecs[0] = '{{256{1'b1}}, 4'd3,  4'd7,  0,   513, 256, 1'b0};
      vecs[1] = '{sparse,      4'd0,  4'd9,  0,   513, 256, 1'b0};
      vecs[2] = '{patt,        4'd9,  4'd0,  0,   513, 256, 1'b0};
      vecs[3] = '{{256{1'b1}}, 4'd5,  4'd5,  0,   1,   0,   1'b0};
      vecs[4] = '{{256{1'b1}}, 4'd12, 4'd3,  0,   1,   0,   1'b1};
      vecs[5] = '{{256{1'b1}}, 4'd4,  4'd15, 0,   1,   0,   1'b1};
      vecs[6] = '{patt,        4'd2,  4'd6,  200, 513, 256, 1'b0};

      #1 rst_n = 1'b0;
      #11;
      check("rst_addr",      96'(u1.bram_addr),     96'd0);
      check("rst_en",        96'(u1.en_update),     96'd0);
      check("rst_deltas",    96'(u1.weight_deltas), 96'd0);
      check("rst_busy",      96'(u1.busy),          96'd0);
      check("rst_done",      96'(u1.done),          96'd0);
      check("rst_label_err", 96'(u1.label_err),     96'd0);
      check("rst_busy2",     96'(u2.busy),          96'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         start_vec(vecs[i]);
         finish_vec($sformatf("v%0d", i), vecs[i]);
      end

      // Reset in the middle of a sweep, then a fresh sweep from address 0.
      start_vec(vecs[0]);
      rel = 0;
      while (u1.bram_addr != 8'd100 && rel < 1000) begin
         @(negedge clk);
         rel++;
      end
      check("reach_addr100", 96'(u1.bram_addr), 96'd100);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_addr",   96'(u1.bram_addr),     96'd0);
      check("async_rst_en",     96'(u1.en_update),     96'd0);
      check("async_rst_deltas", 96'(u1.weight_deltas), 96'd0);
      check("async_rst_busy",   96'(u1.busy),          96'd0);
      check("async_rst_done",   96'(u1.done),          96'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("rst_no_done", 96'(done_cnt), 96'd0);
      rst_n = 1'b1;
      start_vec(vecs[0]);
      finish_vec("after_rst", vecs[0]);

      // RD_LAT=2 instance: three cycles per address.
      @(negedge clk);
      u2.img = {256{1'b1}}; u2.target = 4'd3; u2.predicted = 4'd7; u2.start = 1'b1;
      @(posedge clk);
      #1;
      u2.start = 1'b0;
      rel = 0; hold5 = 0; en2 = 0; d2t = -1; first_t = -1; first_dl = '0;
      while (d2t < 0 && rel < 1200) begin
         @(negedge clk);
         rel++;
         if (u2.busy && u2.bram_addr == 8'd5) hold5++;
         if (u2.en_update) begin
            en2++;
            if (en2 == 1) begin
               first_t  = rel;
               first_dl = u2.weight_deltas;
            end
         end
         if (u2.done) d2t = rel;
      end
      check("lat2_done_cycle",  96'(d2t),      96'd769);
      check("lat2_writes",      96'(en2),      96'd256);
      check("lat2_addr5_hold",  96'(hold5),    96'd3);
      check("lat2_first_write", 96'(first_t),  96'd3);
      check("lat2_deltas",      96'(first_dl), 96'(lanes(4'd3, 4'd7)));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
